// File: rtl/bin_load_ctrl.sv
// Load sequencer for sat_engine: replays one bin (clause rows, var states, level
// states) through the engine write ports, starts the engine and waits for it to finish.
module bin_load_ctrl #(
  parameter int NUM_CLAUSES      = 8,
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic [WIDTH_LVL-1:0]                 cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  input  logic                                 clause_valid_i,
  input  logic                                 clause_last_i,
  input  logic [2*NUM_VARS-1:0]                clause_data_i,
  output logic                                 clause_ready_o,
  output logic [NUM_CLAUSES-1:0]               wr_carray_o,
  output logic [2*NUM_VARS-1:0]                clause_o,
  output logic [NUM_VARS-1:0]                  wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  output logic                                 start_core_o,
  output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]                 load_lvl_o,
  output logic                                 base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]                 base_lvl_o,
  input  logic                                 done_core_i,
  output logic                                 busy_o,
  output logic                                 done_load_o
);

  localparam int RW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int CW = 2 * NUM_VARS;
  localparam int VSW = WIDTH_VAR_STATES * NUM_VARS;
  localparam int LSW = WIDTH_LVL_STATES * NUM_LVLS;
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {IDLE, WR_C, PAD, WR_VS, WR_LS, START, WAIT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [RW-1:0]        row_reg, row_next;
  logic                 accept;
  logic                 ready_next, start_next, base_en_next, busy_next, done_next;
  logic [NUM_CLAUSES-1:0] carray_next, row_onehot;
  logic [CW-1:0]        clause_next;
  logic [NUM_VARS-1:0]  wr_vs_next;
  logic [NUM_LVLS-1:0]  wr_ls_next;
  logic [VSW-1:0]       vs_next;
  logic [LSW-1:0]       ls_next;
  logic [WIDTH_LVL-1:0] bin_next, lvl_next, base_next;

  // ready is registered and only ever high while in WR_C, so it qualifies the handshake
  assign accept     = clause_valid_i & clause_ready_o;
  assign row_onehot = NUM_CLAUSES'(1) << row_reg;

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    carray_next  = '0;
    clause_next  = '0;
    wr_vs_next   = '0;
    wr_ls_next   = '0;
    start_next   = 1'b0;
    base_en_next = 1'b0;
    bin_next     = cur_bin_num_o;
    lvl_next     = load_lvl_o;
    base_next    = base_lvl_o;
    vs_next      = vars_states_o;
    ls_next      = lvl_states_o;
    case (state_reg)
      IDLE: begin
        if (start_load_i) begin
          bin_next   = cur_bin_num_i;
          lvl_next   = load_lvl_i;
          base_next  = base_lvl_i;
          vs_next    = vars_states_i;
          ls_next    = lvl_states_i;
          row_next   = '0;
          state_next = WR_C;
        end
      end
      WR_C: begin
        if (accept) begin
          carray_next = row_onehot;
          clause_next = clause_data_i;
          if (row_reg == LAST_ROW) begin
            row_next   = '0;
            state_next = WR_VS;
          end else begin
            row_next = row_reg + 1'b1;
            if (clause_last_i) state_next = PAD;
          end
        end
      end
      PAD: begin
        // remaining rows are cleared so stale clauses from the previous bin never survive
        carray_next = row_onehot;
        if (row_reg == LAST_ROW) begin
          row_next   = '0;
          state_next = WR_VS;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end
      WR_VS: begin
        wr_vs_next = '1;
        state_next = WR_LS;
      end
      WR_LS: begin
        wr_ls_next = '1;
        state_next = START;
      end
      START: begin
        start_next   = 1'b1;
        base_en_next = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (done_core_i) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == WR_C);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      row_reg         <= '0;
      clause_ready_o  <= 1'b0;
      wr_carray_o     <= '0;
      clause_o        <= '0;
      wr_var_states_o <= '0;
      vars_states_o   <= '0;
      wr_lvl_states_o <= '0;
      lvl_states_o    <= '0;
      start_core_o    <= 1'b0;
      cur_bin_num_o   <= '0;
      load_lvl_o      <= '0;
      base_lvl_en_o   <= 1'b0;
      base_lvl_o      <= '0;
      busy_o          <= 1'b0;
      done_load_o     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      row_reg         <= row_next;
      clause_ready_o  <= ready_next;
      wr_carray_o     <= carray_next;
      clause_o        <= clause_next;
      wr_var_states_o <= wr_vs_next;
      vars_states_o   <= vs_next;
      wr_lvl_states_o <= wr_ls_next;
      lvl_states_o    <= ls_next;
      start_core_o    <= start_next;
      cur_bin_num_o   <= bin_next;
      load_lvl_o      <= lvl_next;
      base_lvl_en_o   <= base_en_next;
      base_lvl_o      <= base_next;
      busy_o          <= busy_next;
      done_load_o     <= done_next;
    end
  end

endmodule

// File: doc/bin_load_ctrl.md
Name: bin_load_ctrl

Overview:
- Upstream sequencer for sat_engine.
- Accepts one bin from the bin manager: a stream of clauses plus the variable-state and level-state snapshots.
- Replays them into the engine's write ports using the one-hot row-write protocol: clause rows first, then var states, then level states. It then pulses start with the base level.
- Waits for done_core_i, then reports completion upstream. Outputs connect directly to the sat_engine load/start ports.

Parameters:
NUM_CLAUSES, 8, clause rows in the engine clause array
NUM_VARS, 8, variables per bin (clause width = 2*NUM_VARS)
NUM_LVLS, 8, level-state entries
WIDTH_LVL, 16, level / bin-number width
WIDTH_VAR_STATES, 19, bits per variable state
WIDTH_LVL_STATES, 16, bits per level state

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_load_i  in  1  begin a load; sampled only in IDLE
cur_bin_num_i  in  WIDTH_LVL  bin number for this load
load_lvl_i  in  WIDTH_LVL  level at which bin is loaded
base_lvl_i  in  WIDTH_LVL  base level for engine
vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  var-state snapshot
lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  level-state snapshot
clause_valid_i  in  1  clause stream valid
clause_last_i  in  1  final clause of bin (qualified by valid)
clause_data_i  in  2*NUM_VARS  clause literals
clause_ready_o  out  1  clause stream ready
wr_carray_o  out  NUM_CLAUSES  one-hot clause row write strobe
clause_o  out  2*NUM_VARS  clause write data
wr_var_states_o  out  NUM_VARS  var-state write enables
vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  var-state write data
wr_lvl_states_o  out  NUM_LVLS  level-state write enables
lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS  level-state write data
start_core_o  out  1  engine start pulse
cur_bin_num_o  out  WIDTH_LVL  held bin number
load_lvl_o  out  WIDTH_LVL  held load level
base_lvl_en_o  out  1  base level load enable, coincident with start
base_lvl_o  out  WIDTH_LVL  held base level
done_core_i  in  1  engine finished
busy_o  out  1  high in every state except IDLE
done_load_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at posedge) forces state IDLE, row counter 0, and every output 0, including all data outputs. Reset mid-operation aborts without any further strobe; the engine is not started.
- All outputs are registered.
- States: IDLE, WR_C, PAD, WR_VS, WR_LS, START, WAIT, DONE.
- IDLE:
  - On start_load_i=1, latch cur_bin_num_i, load_lvl_i, base_lvl_i, vars_states_i and lvl_states_i into the output holding registers, then go to WR_C.
  - done_core_i is ignored in IDLE.
- WR_C:
  - clause_ready_o=1.
  - Each accepted handshake (valid&ready) at row r: next cycle wr_carray_o = 1<<r and clause_o = clause_data_i, for exactly one cycle; r increments.
  - No accept -> wr_carray_o=0. A valid gap inserts idle cycles and no strobe.
  - r width is clog2(NUM_CLAUSES).
  - Accept at r=NUM_CLAUSES-1 -> WR_VS, whether or not last is set.
  - Accept with clause_last_i at r<NUM_CLAUSES-1 -> PAD.
- PAD:
  - clause_ready_o=0.
  - Writes clause_o=0 to each remaining row, one row per cycle, in ascending order.
  - After row NUM_CLAUSES-1 is written -> WR_VS.
  - The clause array is always fully rewritten.
- WR_VS: wr_var_states_o all ones for one cycle, with the latched vars_states_o. Next state WR_LS.
- WR_LS: wr_lvl_states_o all ones for one cycle, with the latched lvl_states_o. Next state START.
- START: start_core_o=1 and base_lvl_en_o=1 for one cycle. cur_bin_num_o, load_lvl_o and base_lvl_o remain held until the next load. Next state WAIT.
- WAIT: on done_core_i=1 -> DONE. done_core_i asserted in any state other than WAIT is ignored.
- DONE: done_load_o=1 for one cycle, then IDLE.
- Strobe ordering: no two of wr_carray_o, wr_var_states_o, wr_lvl_states_o, start_core_o are ever high in the same cycle.
- start_load_i while busy_o=1 is ignored; no queuing.
- A clause beat presented while the block is not in WR_C is not accepted and remains pending at the source.
- Latency with continuous valid and a full bin: start_core_o is high in the 11th cycle after the start_load_i sample edge.

Test Plan:
- Full load, 8 clauses, valid held high, last on the 8th beat:
  - wr_carray_o shows 01,02,...,80 on consecutive cycles with the matching clause data.
  - Then wr_var_states_o=ff, then wr_lvl_states_o=ff, then start_core_o=1 with base_lvl_en_o=1, 11 cycles after start.
  - done_core_i 5 cycles later -> done_load_o pulses once, busy_o falls.
- Short bin, 3 clauses, last on beat 3:
  - Rows 0-2 get the data.
  - Rows 3-7 are written with 0 on consecutive cycles, clause_ready_o=0.
  - Then the var-state and level-state writes and start follow as in the full load.
- Back-pressure, valid toggling 1,0,0,1,...:
  - Exactly one strobe per accepted beat, rows consecutive.
  - No strobe in gap cycles.
  - Total of 8 row strobes.
- start_load_i pulsed during WR_C and again during WAIT with different cur_bin_num_i: ignored; cur_bin_num_o keeps its original value.
- rst=1 after the 4th clause is accepted:
  - Next cycle all outputs are 0, busy_o=0, no start_core_o.
  - A new load afterwards begins at row 0.
- done_core_i pulsed in IDLE and in WR_C: no done_load_o; the sequence is unaffected.
